led_pattern_seq: RTL

LED_PATTERN_SEQ -- requirements
Module: led_pattern_seq

---
 rtl/led_pattern_seq_pkg.sv | 27 ++
 rtl/led_seq_prescaler.sv | 34 +++
 rtl/led_pattern_seq.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/led_pattern_seq_pkg.sv
// Shared state type, PWM width and port-width helpers for the LED pattern sequencer.
package led_pattern_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int PWM_W = 8;

  function automatic int clog2_min1(input int value);
    int w;
    w = $clog2(value);
    return (w < 1) ? 1 : w;
  endfunction

  // One code above the last channel is kept addressable so stray writes can be seen and dropped.
  function automatic int ch_width(input int num_ch);
    return clog2_min1(num_ch + 1);
  endfunction

  // Must hold PAT_LEN itself plus larger requests that get clamped.
  function automatic int len_width(input int pat_len);
    return clog2_min1(pat_len + 1);
  endfunction

endpackage

// File: rtl/led_seq_prescaler.sv
// Step-rate prescaler: counts 0..div and flags the terminal count as a tick.
module led_seq_prescaler
  import led_pattern_seq_pkg::*;
#(
  parameter int DIV_W = 24
) (
  input  logic             clk_16mhz,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  assign tick = (cnt_q == div);

  always_comb begin
    cnt_d = cnt_q + DIV_W'(1);
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_16mhz or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: per-channel bit patterns stepped at a programmable rate.
// Optional PWM dimming (adds the bright port) is enabled by defining LED_PATTERN_SEQ_PWM_EN.
module led_pattern_seq
  import led_pattern_seq_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int PAT_LEN = 32,
  parameter int DIV_W   = 24
) (
  input  logic                          clk_16mhz,
  input  logic                          rst_n,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [ch_width(NUM_CH)-1:0]   cfg_ch,
  input  logic [PAT_LEN-1:0]            cfg_pattern,
  input  logic [DIV_W-1:0]              div,
  input  logic [len_width(PAT_LEN)-1:0] len,
  input  logic                          one_shot,
  input  logic                          start,
  input  logic                          stop,
  output logic                          busy,
  output logic                          done,
  output logic [NUM_CH-1:0]             led,
`ifdef LED_PATTERN_SEQ_PWM_EN
  input  logic [PWM_W-1:0]              bright,
`endif
  output logic                          usb_pullup
);

  localparam int CH_W  = ch_width(NUM_CH);
  localparam int LEN_W = len_width(PAT_LEN);
  localparam int IDX_W = clog2_min1(PAT_LEN);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               one_shot_q, one_shot_d;
  logic               done_q, done_d;
  logic [PAT_LEN-1:0] pattern_q [NUM_CH];
  logic [LEN_W-1:0]   len_eff;
  logic               clear;
  logic               tick;
  logic [NUM_CH-1:0]  led_raw;

  assign usb_pullup = 1'b0;
  assign busy       = (state_q == RUN);
  assign cfg_ready  = ~busy;
  assign done       = done_q;

  led_seq_prescaler #(
    .DIV_W(DIV_W)
  ) u_prescaler (
    .clk_16mhz(clk_16mhz),
    .rst_n    (rst_n),
    .clear    (clear),
    .div      (div_q),
    .tick     (tick)
  );

  // A length of zero, or anything past the stored pattern, means a full-length pass.
  always_comb begin
    len_eff = len;
    if ((len == '0) || (len > LEN_W'(PAT_LEN))) begin
      len_eff = LEN_W'(PAT_LEN);
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    last_d     = last_q;
    div_d      = div_q;
    one_shot_d = one_shot_q;
    done_d     = 1'b0;
    clear      = 1'b0;
    case (state_q)
      IDLE: begin
        clear = 1'b1;
        if (start && !stop) begin
          state_d    = RUN;
          idx_d      = '0;
          last_d     = IDX_W'(len_eff - LEN_W'(1));
          div_d      = div;
          one_shot_d = one_shot;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          idx_d   = '0;
          clear   = 1'b1;
        end else if (tick) begin
          if (idx_q == last_q) begin
            idx_d = '0;
            if (one_shot_q) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_16mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      last_q     <= '0;
      div_q      <= '0;
      one_shot_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      div_q      <= div_d;
      one_shot_q <= one_shot_d;
      done_q     <= done_d;
    end
  end

  // Writes to channels that do not exist match no slot and simply vanish.
  always_ff @(posedge clk_16mhz or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        pattern_q[c] <= '0;
      end
    end else if (cfg_valid && cfg_ready) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (cfg_ch == CH_W'(c)) begin
          pattern_q[c] <= cfg_pattern;
        end
      end
    end
  end

  always_comb begin
    led_raw = '0;
    if (state_q == RUN) begin
      for (int c = 0; c < NUM_CH; c++) begin
        led_raw[c] = pattern_q[c][idx_q];
      end
    end
  end

`ifdef LED_PATTERN_SEQ_PWM_EN
  logic [PWM_W-1:0] pwm_q;

  always_ff @(posedge clk_16mhz or negedge rst_n) begin
    if (!rst_n) begin
      pwm_q <= '0;
    end else begin
      pwm_q <= pwm_q + PWM_W'(1);
    end
  end

  assign led = led_raw & {NUM_CH{pwm_q < bright}};
`else
  assign led = led_raw;
`endif

endmodule
